wb_cpu_bus_arbiter: RTL and testbench
=====================================

Name: wb_cpu_bus_arbiter

Overview:
- Shares one wishbone master bus between the CPU's two connection units: the data-side master (M0, DCMU) and the instruction-side master (M1, ICMU).
- Sits between the CPU's wishbone master ports and the system bus.
- Grants ownership per cycle-frame (from `cyc` assertion until `cyc` drop), so bursts and locked sequences are never split.
- Provides selectable fixed or round-robin priority, plus a bus-timeout watchdog that returns an error to a stuck master.

Parameters:
- ROUND_ROBIN, 1: 0 = M0 always wins a contested arbitration; 1 = the master not granted last wins a contested arbitration.
- TIMEOUT, 1024: number of consecutive cycles with `s_stb_o`=1 and `s_ack_i`=0 before the frame is aborted. 0 disables the watchdog. Maximum value is 65535.

Ports:
- clk  in  1  main clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- m0_cyc_i, m1_cyc_i  in  1  master cycle request.
- m0_stb_i, m1_stb_i  in  1  master strobe.
- m0_addr_i, m1_addr_i  in  30  address [31:2].
- m0_cti_i, m1_cti_i  in  3  cycle type.
- m0_bte_i, m1_bte_i  in  2  burst type.
- m0_sel_i, m1_sel_i  in  4  byte select.
- m0_we_i, m1_we_i  in  1  write enable.
- m0_data_i, m1_data_i  in  32  write data.
- m0_data_o, m1_data_o  out  32  read data (`s_data_i` passthrough).
- m0_ack_o, m1_ack_o  out  1  acknowledge.
- m0_err_o, m1_err_o  out  1  timeout error pulse.
- s_cyc_o, s_stb_o  out  1  bus cycle / strobe.
- s_addr_o  out  30  bus address [31:2].
- s_cti_o  out  3  bus cycle type.
- s_bte_o  out  2  bus burst type.
- s_sel_o  out  4  bus byte select.
- s_we_o  out  1  bus write enable.
- s_data_o  out  32  bus write data.
- s_data_i  in  32  bus read data.
- s_ack_i  in  1  bus acknowledge.
- gnt  out  2  current owner, one-hot: bit0 = M0, bit1 = M1; 00 = none.

Behaviour:
- States: IDLE, OWN0, OWN1, ABORT. A `last` register records the most recently granted master; its reset value is M1, so M0 wins the first contest.
- Reset (rst=0, asynchronous):
  - State = IDLE, `gnt`=00, timeout counter = 0, `last`=M1.
  - All `s_*` outputs = 0; all `m*_ack_o` and `m*_err_o` = 0.
  - `m*_data_o` = `s_data_i` (always).
- Output muxing is combinational from the registered grant:
  - In OWNx, all `s_*` outputs = Mx inputs and `mx_ack_o` = `s_ack_i`.
  - The non-owner's ack is 0. In IDLE and ABORT, all `s_*` outputs are 0.
- Arbitration on each clock edge, evaluated in IDLE or in OWNx when `mx_cyc_i`=0:
  - Requesters are the masters with `cyc`=1, excluding the releasing master if the other master requests.
  - If one requester: grant it. If both: pick per ROUND_ROBIN (M0 when fixed, else the non-`last` master). If none: IDLE.
  - Latency is one cycle from `cyc` rise in IDLE to `s_cyc_o`=1.
  - A handover between masters has zero bubble: the new owner drives the bus on the edge after the old owner's `cyc` falls.
- While in OWNx with `mx_cyc_i`=1, ownership holds regardless of the other request. This covers `stb` gaps, bursts (cti 010) and lock.
- Watchdog (TIMEOUT>0):
  - 16-bit counter increments each OWNx cycle with `s_stb_o`=1 and `s_ack_i`=0.
  - It clears on `s_ack_i`, on `stb`=0, and on grant change.
  - When the counter equals TIMEOUT-1 and `s_ack_i`=0: on the next edge, go to ABORT, pulse `mx_err_o`=1 for exactly that first ABORT cycle, and drop `s_cyc_o`/`s_stb_o`.
  - Remain in ABORT until `mx_cyc_i`=0, then arbitrate as from IDLE. `last` is set to Mx.
- A late `s_ack_i` arriving in ABORT or IDLE is ignored and is not forwarded to any master.
- If `s_ack_i` and the timeout threshold coincide, the ack wins: no abort, counter clears.

Test Plan:
- Single M1 read: `m1_cyc`/`stb` rise at cycle 0 with addr 0x0000100, slave acks at cycle 3 -> `gnt`=10 from cycle 1; `s_addr_o`=0x0000100; `m1_ack_o`=1 at cycle 3 only; `m0_ack_o` stays 0.
- Contest, ROUND_ROBIN=1: both `cyc` rise together after reset -> M0 granted first. M0 drops `cyc` after 1 ack while M1 is still requesting -> `gnt`=10 on the next edge with no IDLE cycle. Both re-request -> M0 wins.
- ROUND_ROBIN=0, M0 holding `cyc` continuously through a 4-beat burst (cti 010,010,010,111) while M1 requests -> all 4 acks go to M0; M1 is granted only after M0 `cyc`=0.
- TIMEOUT=8, M1 strobing with no ack -> `m1_err_o` pulses high once, 8 cycles after `stb`; `s_cyc_o`=0 in the same cycle. A slave ack injected afterwards is not seen on `m1_ack_o`. M1 drops `cyc` -> returns to IDLE.
- Ack arriving exactly in the 8th stalled cycle (TIMEOUT=8) -> normal ack, no `err`, ownership retained.
- rst asserted low mid-burst while owning M0 -> immediately `s_cyc_o`=0, `gnt`=00, no ack or err. After rst release with both requesting -> M0 granted.

Source files
------------

// File: rtl/wb_cpu_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_cpu_bus_arbiter_if
//   Signal bundle between the CPU's two wishbone master ports (M0 = data
//   side, M1 = instruction side), the shared system bus and the arbiter.
//
//   Modports
//     slave  : the arbiter's view. It takes requests from both masters and
//              drives the system bus, the per-master responses and gnt.
//     master : the surrounding environment's view (CPU ports plus the system
//              bus slave). Every direction is the opposite of 'slave'.
//
//   Handshake: a master owns a frame from cyc rise to cyc fall. Inside the
//   frame, a transfer is offered while stb=1 and completes in the cycle the
//   slave returns ack=1. err=1 terminates the frame with an error.
// ---------------------------------------------------------------------------
interface wb_cpu_bus_arbiter_if;
    // Master 0 (data side)
    logic        m0_cyc_i;
    logic        m0_stb_i;
    logic [29:0] m0_addr_i;
    logic [2:0]  m0_cti_i;
    logic [1:0]  m0_bte_i;
    logic [3:0]  m0_sel_i;
    logic        m0_we_i;
    logic [31:0] m0_data_i;
    logic [31:0] m0_data_o;
    logic        m0_ack_o;
    logic        m0_err_o;
    // Master 1 (instruction side)
    logic        m1_cyc_i;
    logic        m1_stb_i;
    logic [29:0] m1_addr_i;
    logic [2:0]  m1_cti_i;
    logic [1:0]  m1_bte_i;
    logic [3:0]  m1_sel_i;
    logic        m1_we_i;
    logic [31:0] m1_data_i;
    logic [31:0] m1_data_o;
    logic        m1_ack_o;
    logic        m1_err_o;
    // Shared system bus
    logic        s_cyc_o;
    logic        s_stb_o;
    logic [29:0] s_addr_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o;
    logic [31:0] s_data_o;
    logic [31:0] s_data_i;
    logic        s_ack_i;
    // Current owner, one-hot (bit0 = M0, bit1 = M1)
    logic [1:0]  gnt;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_addr_i, m0_cti_i, m0_bte_i, m0_sel_i,
               m0_we_i, m0_data_i,
        input  m1_cyc_i, m1_stb_i, m1_addr_i, m1_cti_i, m1_bte_i, m1_sel_i,
               m1_we_i, m1_data_i,
        input  s_data_i, s_ack_i,
        output m0_data_o, m0_ack_o, m0_err_o,
        output m1_data_o, m1_ack_o, m1_err_o,
        output s_cyc_o, s_stb_o, s_addr_o, s_cti_o, s_bte_o, s_sel_o,
               s_we_o, s_data_o,
        output gnt
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_addr_i, m0_cti_i, m0_bte_i, m0_sel_i,
               m0_we_i, m0_data_i,
        output m1_cyc_i, m1_stb_i, m1_addr_i, m1_cti_i, m1_bte_i, m1_sel_i,
               m1_we_i, m1_data_i,
        output s_data_i, s_ack_i,
        input  m0_data_o, m0_ack_o, m0_err_o,
        input  m1_data_o, m1_ack_o, m1_err_o,
        input  s_cyc_o, s_stb_o, s_addr_o, s_cti_o, s_bte_o, s_sel_o,
               s_we_o, s_data_o,
        input  gnt
    );
endinterface

// File: rtl/wb_cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_cpu_bus_arbiter
//   Shares one wishbone bus between the CPU data-side master (M0) and the
//   instruction-side master (M1). Ownership is granted per cyc frame so
//   bursts and locked sequences are never split. Contested arbitration is
//   fixed (M0 wins) or round-robin (the master not granted last wins). A
//   watchdog aborts a frame that stalls for TIMEOUT cycles and pulses the
//   owner's err for one cycle.
//
//   Ports
//     clk       : clock
//     rst       : asynchronous active-low reset
//     bus       : wb_cpu_bus_arbiter_if.slave (both masters, system bus, gnt)
//     fsm_state : arbiter state (0 IDLE, 1 OWN0, 2 OWN1, 3 ABORT)
// ---------------------------------------------------------------------------
module wb_cpu_bus_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    wb_cpu_bus_arbiter_if.slave         bus,
    output logic [1:0]                  fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_n;
    logic        last, last_n;      // 0 = M0 granted last, 1 = M1
    logic [15:0] cnt, cnt_n;
    logic [1:0]  err_q, err_n;
    logic        stall;
    logic        timeout_hit;

    // Winner among current requesters; the releasing owner has already
    // dropped cyc, so it never competes with the other master.
    function automatic state_t arbitrate(input logic c0, input logic c1,
                                         input logic lst);
        if (c0 && c1)
            return (ROUND_ROBIN != 0 && !lst) ? OWN1 : OWN0;
        else if (c0)
            return OWN0;
        else if (c1)
            return OWN1;
        else
            return IDLE;
    endfunction

    assign stall       = bus.s_stb_o && !bus.s_ack_i;
    // A coincident ack clears stall, so the ack wins over the threshold.
    assign timeout_hit = (TIMEOUT != 0) && stall && (cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= 16'd0;
            err_q <= 2'b00;
        end else begin
            state <= state_n;
            last  <= last_n;
            cnt   <= cnt_n;
            err_q <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        last_n  = last;
        err_n   = 2'b00;
        case (state)
            IDLE: state_n = arbitrate(bus.m0_cyc_i, bus.m1_cyc_i, last);
            OWN0: begin
                if (!bus.m0_cyc_i)
                    state_n = arbitrate(bus.m0_cyc_i, bus.m1_cyc_i, last);
                else if (timeout_hit) begin
                    state_n = ABORT;
                    err_n   = 2'b01;
                end
            end
            OWN1: begin
                if (!bus.m1_cyc_i)
                    state_n = arbitrate(bus.m0_cyc_i, bus.m1_cyc_i, last);
                else if (timeout_hit) begin
                    state_n = ABORT;
                    err_n   = 2'b10;
                end
            end
            ABORT: begin
                // The aborted master is the one granted last.
                if (last ? !bus.m1_cyc_i : !bus.m0_cyc_i)
                    state_n = arbitrate(bus.m0_cyc_i, bus.m1_cyc_i, last);
            end
            default: state_n = IDLE;
        endcase

        if (state_n == OWN0 && state != OWN0)
            last_n = 1'b0;
        else if (state_n == OWN1 && state != OWN1)
            last_n = 1'b1;

        // Counts consecutive stalled cycles of the same owner; any grant
        // change, ack or stb gap restarts it.
        if (state_n == state && (state == OWN0 || state == OWN1) && stall)
            cnt_n = cnt + 16'd1;
        else
            cnt_n = 16'd0;
    end

    always_comb begin
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_addr_o = 30'd0;
        bus.s_cti_o  = 3'd0;
        bus.s_bte_o  = 2'd0;
        bus.s_sel_o  = 4'd0;
        bus.s_we_o   = 1'b0;
        bus.s_data_o = 32'd0;
        bus.m0_ack_o = 1'b0;
        bus.m1_ack_o = 1'b0;
        bus.gnt      = 2'b00;
        case (state)
            OWN0: begin
                bus.s_cyc_o  = bus.m0_cyc_i;
                bus.s_stb_o  = bus.m0_stb_i;
                bus.s_addr_o = bus.m0_addr_i;
                bus.s_cti_o  = bus.m0_cti_i;
                bus.s_bte_o  = bus.m0_bte_i;
                bus.s_sel_o  = bus.m0_sel_i;
                bus.s_we_o   = bus.m0_we_i;
                bus.s_data_o = bus.m0_data_i;
                bus.m0_ack_o = bus.s_ack_i;
                bus.gnt      = 2'b01;
            end
            OWN1: begin
                bus.s_cyc_o  = bus.m1_cyc_i;
                bus.s_stb_o  = bus.m1_stb_i;
                bus.s_addr_o = bus.m1_addr_i;
                bus.s_cti_o  = bus.m1_cti_i;
                bus.s_bte_o  = bus.m1_bte_i;
                bus.s_sel_o  = bus.m1_sel_i;
                bus.s_we_o   = bus.m1_we_i;
                bus.s_data_o = bus.m1_data_i;
                bus.m1_ack_o = bus.s_ack_i;
                bus.gnt      = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus.m0_data_o = bus.s_data_i;
    assign bus.m1_data_o = bus.s_data_i;
    assign bus.m0_err_o  = err_q[0];
    assign bus.m1_err_o  = err_q[1];
    assign fsm_state     = state;

endmodule

// File: tb/tb_wb_cpu_bus_arbiter.sv
module tb_wb_cpu_bus_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus variables ----------------
    logic        c  [2];
    logic        s  [2];
    logic [29:0] ad [2];
    logic [2:0]  ct [2];
    logic [1:0]  bt [2];
    logic [3:0]  se [2];
    logic        we [2];
    logic [31:0] wd [2];
    logic [31:0] sdi;
    logic        sack;

    wb_cpu_bus_arbiter_if bus_a ();
    wb_cpu_bus_arbiter_if bus_b ();
    logic [1:0] st_a, st_b;

    // Instance A: round robin, watchdog 8. Instance B: fixed, no watchdog.
    wb_cpu_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .fsm_state(st_a));
    wb_cpu_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .fsm_state(st_b));

    assign bus_a.m0_cyc_i = c[0];  assign bus_b.m0_cyc_i = c[0];
    assign bus_a.m0_stb_i = s[0];  assign bus_b.m0_stb_i = s[0];
    assign bus_a.m0_addr_i = ad[0]; assign bus_b.m0_addr_i = ad[0];
    assign bus_a.m0_cti_i = ct[0]; assign bus_b.m0_cti_i = ct[0];
    assign bus_a.m0_bte_i = bt[0]; assign bus_b.m0_bte_i = bt[0];
    assign bus_a.m0_sel_i = se[0]; assign bus_b.m0_sel_i = se[0];
    assign bus_a.m0_we_i = we[0];  assign bus_b.m0_we_i = we[0];
    assign bus_a.m0_data_i = wd[0]; assign bus_b.m0_data_i = wd[0];
    assign bus_a.m1_cyc_i = c[1];  assign bus_b.m1_cyc_i = c[1];
    assign bus_a.m1_stb_i = s[1];  assign bus_b.m1_stb_i = s[1];
    assign bus_a.m1_addr_i = ad[1]; assign bus_b.m1_addr_i = ad[1];
    assign bus_a.m1_cti_i = ct[1]; assign bus_b.m1_cti_i = ct[1];
    assign bus_a.m1_bte_i = bt[1]; assign bus_b.m1_bte_i = bt[1];
    assign bus_a.m1_sel_i = se[1]; assign bus_b.m1_sel_i = se[1];
    assign bus_a.m1_we_i = we[1];  assign bus_b.m1_we_i = we[1];
    assign bus_a.m1_data_i = wd[1]; assign bus_b.m1_data_i = wd[1];
    assign bus_a.s_data_i = sdi;   assign bus_b.s_data_i = sdi;
    assign bus_a.s_ack_i = sack;   assign bus_b.s_ack_i = sack;

    // Observed outputs gathered per instance.
    logic [73:0] bus_obs [2];
    logic [67:0] rsp_obs [2];
    logic [3:0]  st_obs  [2];
    assign bus_obs[0] = {bus_a.s_cyc_o, bus_a.s_stb_o, bus_a.s_addr_o, bus_a.s_cti_o,
                         bus_a.s_bte_o, bus_a.s_sel_o, bus_a.s_we_o, bus_a.s_data_o};
    assign bus_obs[1] = {bus_b.s_cyc_o, bus_b.s_stb_o, bus_b.s_addr_o, bus_b.s_cti_o,
                         bus_b.s_bte_o, bus_b.s_sel_o, bus_b.s_we_o, bus_b.s_data_o};
    assign rsp_obs[0] = {bus_a.m0_ack_o, bus_a.m1_ack_o, bus_a.m0_err_o, bus_a.m1_err_o,
                         bus_a.m0_data_o, bus_a.m1_data_o};
    assign rsp_obs[1] = {bus_b.m0_ack_o, bus_b.m1_ack_o, bus_b.m0_err_o, bus_b.m1_err_o,
                         bus_b.m0_data_o, bus_b.m1_data_o};
    assign st_obs[0]  = {bus_a.gnt, st_a};
    assign st_obs[1]  = {bus_b.gnt, st_b};

    // ---------------- reference model ----------------
    // Per instance: who owns the bus (-1 none), who is being aborted
    // (-1 none), how many stalled cycles in a row, who was granted last,
    // and whose err pulse is showing this cycle.
    int rr_cfg [2] = '{1, 0};
    int to_cfg [2] = '{8, 0};
    int own    [2];
    int abrt   [2];
    int stalls [2];
    int last   [2];
    int errp   [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [79:0] obs,
                         input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k] = -1; abrt[k] = -1; stalls[k] = 0; last[k] = 1; errp[k] = -1;
        end
    endtask

    function automatic int pick(int k);
        if (c[0] && c[1]) return (rr_cfg[k] != 0) ? 1 - last[k] : 0;
        if (c[0]) return 0;
        if (c[1]) return 1;
        return -1;
    endfunction

    task automatic grant(int k);
        own[k]    = pick(k);
        stalls[k] = 0;
        if (own[k] >= 0) last[k] = own[k];
    endtask

    task automatic model_step(int k);
        errp[k] = -1;
        if (abrt[k] >= 0) begin
            if (!c[abrt[k]]) begin
                abrt[k] = -1;
                grant(k);
            end
        end else if (own[k] >= 0) begin
            if (c[own[k]]) begin
                if (s[own[k]] && !sack) begin
                    stalls[k]++;
                    if (to_cfg[k] > 0 && stalls[k] >= to_cfg[k]) begin
                        abrt[k] = own[k]; errp[k] = own[k];
                        own[k] = -1; stalls[k] = 0;
                    end
                end else begin
                    stalls[k] = 0;
                end
            end else begin
                grant(k);
            end
        end else begin
            grant(k);
        end
    endtask

    task automatic check_all();
        logic [73:0] eb;
        logic [67:0] er;
        logic [3:0]  es;
        int          x;
        for (int k = 0; k < 2; k++) begin
            x  = own[k];
            eb = '0;
            if (x >= 0) eb = {c[x], s[x], ad[x], ct[x], bt[x], se[x], we[x], wd[x]};
            er = {(x == 0) && sack, (x == 1) && sack, errp[k] == 0, errp[k] == 1, sdi, sdi};
            es[3:2] = (x == 0) ? 2'b01 : (x == 1) ? 2'b10 : 2'b00;
            es[1:0] = (abrt[k] >= 0) ? 2'd3 : 2'(x + 1);
            check(k == 0 ? "bus_a" : "bus_b", 80'(bus_obs[k]), 80'(eb));
            check(k == 0 ? "rsp_a" : "rsp_b", 80'(rsp_obs[k]), 80'(er));
            check(k == 0 ? "gnt_a" : "gnt_b", 80'(st_obs[k]), 80'(es));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge: apply inputs, check, advance model.
    task automatic step();
        #1;
        if (!rst) model_reset();
        check_all();
        if (rst) for (int k = 0; k < 2; k++) model_step(k);
        @(negedge clk);
    endtask

    task automatic drive(input logic c0, input logic s0, input logic c1,
                         input logic s1, input logic ack);
        c[0] = c0; s[0] = s0; c[1] = c1; s[1] = s1; sack = ack;
        for (int i = 0; i < 2; i++) begin
            ad[i] = 30'($urandom); ct[i] = 3'($urandom_range(0, 7));
            bt[i] = 2'($urandom_range(0, 3)); se[i] = 4'($urandom_range(0, 15));
            we[i] = 1'($urandom_range(0, 1)); wd[i] = $urandom;
        end
        sdi = $urandom;
        step();
    endtask

    task automatic rand_cycle(input int ack_pct);
        logic nc [2];
        logic ns [2];
        for (int i = 0; i < 2; i++) begin
            if (!c[i]) nc[i] = ($urandom_range(0, 99) < 30);
            else       nc[i] = ($urandom_range(0, 99) >= 12);
            ns[i] = nc[i] && ($urandom_range(0, 3) != 0);
        end
        drive(nc[0], ns[0], nc[1], ns[1], $urandom_range(0, 99) < ack_pct);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int pct_tab [4] = '{0, 15, 50, 90};
        for (int i = 0; i < 2; i++) begin
            c[i] = 0; s[i] = 0; ad[i] = '0; ct[i] = '0; bt[i] = '0;
            se[i] = '0; we[i] = 0; wd[i] = '0;
        end
        sdi = '0; sack = 0;
        model_reset();
        @(negedge clk);
        drive(1, 1, 1, 1, 1);          // reset state with requests and ack present
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;

        // Single M1 read, ack in the fourth cycle.
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, i == 3);
        drive(0, 0, 0, 0, 0);

        // Contest, handover without bubble, re-contest.
        drive(1, 1, 1, 1, 0);
        drive(1, 1, 1, 1, 1);
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 1, 1);
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 0);
        drive(1, 1, 1, 1, 1);
        drive(0, 0, 0, 0, 0);

        // M0 burst held against a competing M1.
        drive(1, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 1, 1);
        drive(0, 0, 1, 1, 1);
        drive(0, 0, 0, 0, 0);

        // M1 stalls past the watchdog, late ack, then releases.
        for (int i = 0; i < 12; i++) drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 1, 1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);

        // Ack lands in the eighth stalled cycle.
        for (int i = 0; i < 9; i++) drive(0, 0, 1, 1, i == 8);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0);

        // Randomized traffic with varying slave responsiveness.
        for (int p = 0; p < 16; p++) begin
            for (int i = 0; i < 150; i++) rand_cycle(pct_tab[p % 4]);
        end

        // Asynchronous reset in the middle of an M0 burst.
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 1);
        #2 rst = 1'b0;
        drive(1, 1, 1, 1, 1);
        drive(1, 1, 1, 1, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 1, 0);
        drive(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
